alu_exec_unit: RTL

- Parametrised successor to the single-ALU reservation-station unit.
- Accepts issued ALU micro-ops with their ROB tags via a valid/ready handshake and computes the result combinationally.
- Buffers tag+result pairs in a parametrised result FIFO until the common data bus (CDB) arbiter grants a broadcast slot.
- Sits between the issue/RS stage and the CDB arbiter; supports pipeline flush.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_result_fifo.sv | 65 ++++++
 rtl/alu_exec_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: opcode encodings and the
// default-width CDB packet used by consumers built at XLEN=32 / TAG_W=6.
package alu_pkg;

  localparam int unsigned XlenDef  = 32;
  localparam int unsigned TagWDef  = 6;
  localparam int unsigned AluOpW   = 4;

  localparam logic [AluOpW-1:0] AluAdd   = 4'd0;
  localparam logic [AluOpW-1:0] AluSub   = 4'd1;
  localparam logic [AluOpW-1:0] AluSll   = 4'd2;
  localparam logic [AluOpW-1:0] AluSlt   = 4'd3;
  localparam logic [AluOpW-1:0] AluSltu  = 4'd4;
  localparam logic [AluOpW-1:0] AluXor   = 4'd5;
  localparam logic [AluOpW-1:0] AluSrl   = 4'd6;
  localparam logic [AluOpW-1:0] AluSra   = 4'd7;
  localparam logic [AluOpW-1:0] AluOr    = 4'd8;
  localparam logic [AluOpW-1:0] AluAnd   = 4'd9;
  localparam logic [AluOpW-1:0] AluPass2 = 4'd10;

  typedef struct packed {
    logic [TagWDef-1:0] tag;
    logic [XlenDef-1:0] value;
  } cdb_pkt_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Count-based synchronous FIFO with synchronous flush and async active-high reset.
// Head data is read straight from register storage and forced to zero when empty.
module alu_result_fifo #(
  parameter int unsigned Width = 38,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Qualify requests: no pop from empty, push into full only alongside a pop.
  always_comb begin
    do_pop  = pop_i & (count_q != '0);
    do_push = push_i & ((count_q != FullCnt) | do_pop);
  end

  // Pointer and occupancy state; flush overrides any push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Entry storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Status and head data.
  always_comb begin
    count_o = count_q;
    full_o  = (count_q == FullCnt);
    empty_o = (count_q == '0);
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: computes issued micro-ops combinationally and queues
// tag/result pairs until the CDB arbiter grants a broadcast.
// Optional: define ALU_EXEC_BYPASS_EN to let a result skip the empty FIFO and
// broadcast in its issue cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [XLEN-1:0]               issue_v1_i,
  input  logic [XLEN-1:0]               issue_v2_i,
  input  logic [OP_W-1:0]               issue_op_i,
  input  logic [TAG_W-1:0]              issue_tag_i,
  input  logic                          flush_i,
  input  logic                          cdb_grant_i,
  output logic                          cdb_valid_o,
  output logic [TAG_W-1:0]              cdb_tag_o,
  output logic [XLEN-1:0]               cdb_value_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned EntW = TAG_W + XLEN;

  function automatic logic [XLEN-1:0] alu_compute(input logic [OP_W-1:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [ShW-1:0] sh;
    sh = b[ShW-1:0];
    case (op)
      AluAdd:   return a + b;
      AluSub:   return a - b;
      AluSll:   return a << sh;
      AluSlt:   return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      AluSltu:  return {{(XLEN-1){1'b0}}, (a < b)};
      AluXor:   return a ^ b;
      AluSrl:   return a >> sh;
      AluSra:   return $unsigned($signed(a) >>> sh);
      AluOr:    return a | b;
      AluAnd:   return a & b;
      AluPass2: return b;
      default:  return '0;
    endcase
  endfunction

  logic [XLEN-1:0] alu_res;
  logic [EntW-1:0] head;
  logic            bypass, pop, fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Datapath result for the op currently presented at issue.
  always_comb begin
    alu_res = alu_compute(issue_op_i, issue_v1_i, issue_v2_i);
  end

  // Handshake, FIFO control and CDB output selection.
  always_comb begin
    bypass = 1'b0;
`ifdef ALU_EXEC_BYPASS_EN
    bypass = fifo_empty & issue_valid_i & ~flush_i;
`endif
    cdb_valid_o   = ~fifo_empty | bypass;
    pop           = cdb_grant_i & cdb_valid_o;
    issue_ready_o = ~fifo_full | pop;
    // A granted bypass consumes the op directly; nothing reaches storage.
    fifo_pop      = pop & ~bypass;
    fifo_push     = issue_valid_i & issue_ready_o & ~flush_i & ~(bypass & cdb_grant_i);
    if (bypass) begin
      cdb_tag_o   = issue_tag_i;
      cdb_value_o = alu_res;
    end else begin
      cdb_tag_o   = head[EntW-1:XLEN];
      cdb_value_o = head[XLEN-1:0];
    end
    fifo_count_o = fifo_count;
    fifo_full_o  = fifo_full;
    fifo_empty_o = fifo_empty;
  end

  alu_result_fifo #(
    .Width (EntW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (flush_i),
    .wdata_i ({issue_tag_i, alu_res}),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
